riscv_scoreboard_hazard_unit: RTL and testbench
===============================================

Name: riscv_scoreboard_hazard_unit

Overview:
Parametrised hazard and forwarding controller for the 5-stage RV32I pipeline. It replaces fixed-latency load-use detection with a per-register scoreboard, so data memory may return load data a variable number of cycles later on a separate response port. It produces the stall, flush and forward-select controls consumed by the pipeline datapath, and has a no-forwarding mode for area-reduced builds.

Parameters:
NREG, 32, number of architectural registers; address width AW = $clog2(NREG)
MAX_OUT, 4, maximum outstanding loads (issued, no response yet); 1..15
FWD_EN, 1, 1 = forwarding enabled; 0 = resolve every RAW hazard by stalling

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  synchronous reset, active-high
i_rs1_addr_d  in  AW  decode-stage rs1 address
i_rs2_addr_d  in  AW  decode-stage rs2 address
i_rs1_used_d  in  1  decode instruction reads rs1
i_rs2_used_d  in  1  decode instruction reads rs2
i_rd_addr_d  in  AW  decode-stage rd address
i_reg_wr_en_d  in  1  decode instruction writes rd
i_is_load_d  in  1  decode instruction is a load
i_rs1_addr_e  in  AW  execute-stage rs1
i_rs2_addr_e  in  AW  execute-stage rs2
i_rd_addr_e  in  AW  execute-stage rd
i_reg_wr_en_e  in  1  execute-stage register write enable
i_is_load_e  in  1  execute instruction is a load
i_rd_addr_m  in  AW  memory-stage rd
i_reg_wr_en_m  in  1  memory-stage non-load register write
i_rd_addr_w  in  AW  writeback-stage rd
i_reg_wr_en_w  in  1  writeback-stage register write
i_ld_issue  in  1  load accepted by data memory this cycle (M stage)
i_ld_issue_rd  in  AW  destination of the issuing load
i_ld_resp_valid  in  1  load data is written to the register file this cycle
i_ld_resp_rd  in  AW  destination of the returning load
i_redirect_e  in  1  taken branch/jump resolved in E
o_stall_f  out  1  hold PC
o_stall_d  out  1  hold the F/D register
o_flush_d  out  1  clear the F/D register
o_flush_e  out  1  clear the D/E register (insert bubble)
o_fwd_ae  out  2  ALU operand A source: 00 regfile, 01 W, 10 M, 11 load response
o_fwd_be  out  2  ALU operand B source, same encoding
o_busy_vec  out  NREG  scoreboard, bit r = load pending to r
o_ld_cnt  out  4  outstanding-load count

Behaviour:
- Reset (i_rst high at an edge): busy_vec = 0 and ld_cnt = 0. While i_rst is high, all outputs read 0, including the combinational ones. Reset asserted mid-operation discards pending loads, and any later responses to them are ignored.
- Scoreboard update at each edge, applied in order clear then set:
  - clear bit i_ld_resp_rd if i_ld_resp_valid;
  - set bit i_ld_issue_rd if i_ld_issue and rd != 0.
  - If a set and a clear hit the same register in one cycle, the set wins.
  - Register x0 is never set.
- Counter: ld_cnt += i_ld_issue − i_ld_resp_valid at each edge. It saturates at 0 and at MAX_OUT. An issue while full, or a response while empty, is a protocol error and leaves the count unchanged.
- Decode hazards use only the registered busy_vec (no response bypass). Let src(r) = (rs1_used & rs1_d == r) | (rs2_used & rs2_d == r), with r != 0.
  - RAW-load: src matches a busy register, OR rd_e when i_is_load_e, OR i_ld_issue_rd when i_ld_issue.
  - WAW: i_reg_wr_en_d and rd_d matches any of the same three sources.
  - Full: i_is_load_d and (ld_cnt + i_is_load_e + i_ld_issue) >= MAX_OUT.
  - FWD_EN=0 only: src matches rd_e, rd_m or rd_w with the corresponding write enable set.
  - If any of these holds, stall = 1.
- Outputs:
  - stall=1 and i_redirect_e=0: o_stall_f = o_stall_d = 1, o_flush_e = 1.
  - i_redirect_e=1: o_flush_d = o_flush_e = 1 and o_stall_f = o_stall_d = 0. Redirect has priority over stall.
- Forwarding (FWD_EN=1), for each E operand with address r != 0:
  - 10 if i_reg_wr_en_m & rd_m == r;
  - else 11 if i_ld_resp_valid & resp_rd == r;
  - else 01 if i_reg_wr_en_w & rd_w == r;
  - else 00.
  - With FWD_EN=0, both selects are constant 00.
- Stall, flush and forward outputs are combinational from the inputs and registered state, with zero latency. busy_vec and ld_cnt update one cycle after issue/response.

Test Plan:
- Reset: hold i_rst 2 cycles with random inputs -> all outputs 0, busy_vec = 0, ld_cnt = 0.
- Variable-latency load-use: issue load to x5, response 6 cycles later, decode reads x5 -> stall_f/stall_d/flush_e held high from the issue cycle through the response cycle, low the following cycle; busy_vec[5] clears one cycle after the response.
- Forward priority: M writes x3, response for x3 and W writes x3 in the same cycle, E reads x3 on rs1 and rs2 -> fwd_ae = fwd_be = 10. Drop M -> 11. Drop the response -> 01.
- Outstanding limit, MAX_OUT=4: four issues without responses, then a load in D -> stall asserted, ld_cnt = 4. One response -> stall released the next cycle.
- Redirect during stall: load-use stall active and i_redirect_e=1 -> flush_d = flush_e = 1, stall_f = stall_d = 0.
- FWD_EN=0 build: ADD x1 in E, decode reads x1 -> stall for 3 cycles, fwd_ae = 00 throughout. x0 as source or destination never stalls.

Source files
------------

// File: rtl/riscv_scoreboard_hazard_unit.sv
// rtl/riscv_scoreboard_hazard_unit.sv - scoreboard-based hazard, stall/flush and forwarding control for a 5-stage RV32I pipeline
//
// Purpose:
//   Tracks destination registers of loads that memory has accepted but whose
//   data has not yet been written back (variable latency), counts outstanding
//   loads, and derives the pipeline stall, flush and operand-forwarding
//   controls. With FWD_EN = 0, every RAW hazard against E/M/W is resolved by
//   stalling decode, and the forward selects stay at the register file.
//
// Ports:
//   i_clk, i_rst                  clock (rising edge), synchronous active-high reset
//   i_rs1/rs2_addr_d, *_used_d    decode-stage source operands
//   i_rd_addr_d, i_reg_wr_en_d    decode-stage destination
//   i_is_load_d                   decode instruction is a load
//   i_rs1/rs2_addr_e, i_rd_addr_e execute-stage operands and destination
//   i_reg_wr_en_e, i_is_load_e    execute-stage write enable / load flag
//   i_rd_addr_m, i_reg_wr_en_m    memory-stage non-load write
//   i_rd_addr_w, i_reg_wr_en_w    writeback-stage write
//   i_ld_issue, i_ld_issue_rd     load accepted by data memory this cycle
//   i_ld_resp_valid, i_ld_resp_rd load data written to the register file this cycle
//   i_redirect_e                  taken branch/jump resolved in E
//   o_stall_f, o_stall_d          hold PC / hold F-D register
//   o_flush_d, o_flush_e          clear F-D / clear D-E (bubble)
//   o_fwd_ae, o_fwd_be            E operand source: 00 regfile, 01 W, 10 M, 11 load response
//   o_busy_vec                    bit r set = load pending to register r
//   o_ld_cnt                      number of outstanding loads

module riscv_scoreboard_hazard_unit #(
    parameter int NREG    = 32,
    parameter int MAX_OUT = 4,
    parameter int FWD_EN  = 1,
    localparam int AW     = $clog2(NREG)
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [AW-1:0]   i_rs1_addr_d,
    input  logic [AW-1:0]   i_rs2_addr_d,
    input  logic            i_rs1_used_d,
    input  logic            i_rs2_used_d,
    input  logic [AW-1:0]   i_rd_addr_d,
    input  logic            i_reg_wr_en_d,
    input  logic            i_is_load_d,
    input  logic [AW-1:0]   i_rs1_addr_e,
    input  logic [AW-1:0]   i_rs2_addr_e,
    input  logic [AW-1:0]   i_rd_addr_e,
    input  logic            i_reg_wr_en_e,
    input  logic            i_is_load_e,
    input  logic [AW-1:0]   i_rd_addr_m,
    input  logic            i_reg_wr_en_m,
    input  logic [AW-1:0]   i_rd_addr_w,
    input  logic            i_reg_wr_en_w,
    input  logic            i_ld_issue,
    input  logic [AW-1:0]   i_ld_issue_rd,
    input  logic            i_ld_resp_valid,
    input  logic [AW-1:0]   i_ld_resp_rd,
    input  logic            i_redirect_e,
    output logic            o_stall_f,
    output logic            o_stall_d,
    output logic            o_flush_d,
    output logic            o_flush_e,
    output logic [1:0]      o_fwd_ae,
    output logic [1:0]      o_fwd_be,
    output logic [NREG-1:0] o_busy_vec,
    output logic [3:0]      o_ld_cnt
);

    localparam logic [1:0] FWD_RF   = 2'b00;
    localparam logic [1:0] FWD_W    = 2'b01;
    localparam logic [1:0] FWD_M    = 2'b10;
    localparam logic [1:0] FWD_RESP = 2'b11;

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_nxt;
    logic [3:0]      cnt_q;
    logic [3:0]      cnt_nxt;

    // ------------------------------------------------------------------
    // Scoreboard: clear on response first, then set on issue, so an issue
    // and a response to the same register in one cycle leave it busy.
    // ------------------------------------------------------------------
    always_comb begin
        busy_nxt = busy_q;
        for (int r = 0; r < NREG; r++) begin
            if (i_ld_resp_valid && (i_ld_resp_rd == AW'(r))) begin
                busy_nxt[r] = 1'b0;
            end
        end
        for (int r = 1; r < NREG; r++) begin
            if (i_ld_issue && (i_ld_issue_rd == AW'(r))) begin
                busy_nxt[r] = 1'b1;
            end
        end
        busy_nxt[0] = 1'b0;
    end

    // Saturating count; an issue while full or a response while empty is
    // a protocol violation and is dropped rather than wrapping the count.
    always_comb begin
        cnt_nxt = cnt_q;
        if (i_ld_issue && !i_ld_resp_valid) begin
            if (cnt_q < 4'(MAX_OUT)) begin
                cnt_nxt = cnt_q + 4'd1;
            end
        end else if (!i_ld_issue && i_ld_resp_valid) begin
            if (cnt_q != 4'd0) begin
                cnt_nxt = cnt_q - 4'd1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            busy_q <= '0;
            cnt_q  <= 4'd0;
        end else begin
            busy_q <= busy_nxt;
            cnt_q  <= cnt_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Decode hazard detection. Only the registered scoreboard is used; a
    // response arriving this cycle does not release decode until next cycle.
    // ------------------------------------------------------------------

    // A load to r is pending if the scoreboard says so, a load sits in E,
    // or a load is being accepted by memory right now.
    function automatic logic load_pending(
        input logic [NREG-1:0] busy,
        input logic [AW-1:0]   r,
        input logic            ld_e,
        input logic [AW-1:0]   rd_e,
        input logic            ld_iss,
        input logic [AW-1:0]   iss_rd
    );
        return busy[r] || (ld_e && (rd_e == r)) || (ld_iss && (iss_rd == r));
    endfunction

    // A non-load result to r still in flight in E, M or W.
    function automatic logic alu_pending(
        input logic [AW-1:0] r,
        input logic          wr_e,
        input logic [AW-1:0] rd_e,
        input logic          wr_m,
        input logic [AW-1:0] rd_m,
        input logic          wr_w,
        input logic [AW-1:0] rd_w
    );
        return (wr_e && (rd_e == r)) || (wr_m && (rd_m == r)) || (wr_w && (rd_w == r));
    endfunction

    logic       rs1_live;
    logic       rs2_live;
    logic       rd_live;
    logic       raw_load;
    logic       waw_load;
    logic       ld_full;
    logic       raw_alu;
    logic       stall;
    logic [4:0] ld_demand;

    assign rs1_live = i_rs1_used_d && (i_rs1_addr_d != '0);
    assign rs2_live = i_rs2_used_d && (i_rs2_addr_d != '0);
    assign rd_live  = i_reg_wr_en_d && (i_rd_addr_d != '0);

    assign raw_load =
        (rs1_live && load_pending(busy_q, i_rs1_addr_d, i_is_load_e, i_rd_addr_e,
                                  i_ld_issue, i_ld_issue_rd)) ||
        (rs2_live && load_pending(busy_q, i_rs2_addr_d, i_is_load_e, i_rd_addr_e,
                                  i_ld_issue, i_ld_issue_rd));

    // Writing rd before an older load to rd completes would let the late
    // load response overwrite the newer value.
    assign waw_load =
        rd_live && load_pending(busy_q, i_rd_addr_d, i_is_load_e, i_rd_addr_e,
                                i_ld_issue, i_ld_issue_rd);

    // Loads in E and at the memory port will occupy slots before this one.
    assign ld_demand = {1'b0, cnt_q} + 5'(i_is_load_e) + 5'(i_ld_issue);
    assign ld_full   = i_is_load_d && (ld_demand >= 5'(MAX_OUT));

    assign raw_alu = (FWD_EN == 0) && (
        (rs1_live && alu_pending(i_rs1_addr_d, i_reg_wr_en_e, i_rd_addr_e,
                                 i_reg_wr_en_m, i_rd_addr_m, i_reg_wr_en_w, i_rd_addr_w)) ||
        (rs2_live && alu_pending(i_rs2_addr_d, i_reg_wr_en_e, i_rd_addr_e,
                                 i_reg_wr_en_m, i_rd_addr_m, i_reg_wr_en_w, i_rd_addr_w)));

    assign stall = !i_rst && (raw_load || waw_load || ld_full || raw_alu);

    // A redirect squashes the stalled decode instruction anyway, so it wins.
    assign o_stall_f = stall && !i_redirect_e;
    assign o_stall_d = stall && !i_redirect_e;
    assign o_flush_d = !i_rst && i_redirect_e;
    assign o_flush_e = !i_rst && (i_redirect_e || stall);

    // ------------------------------------------------------------------
    // Forwarding: youngest producer wins (M, then load response, then W).
    // ------------------------------------------------------------------
    function automatic logic [1:0] fwd_sel(
        input logic [AW-1:0] r,
        input logic          wr_m,
        input logic [AW-1:0] rd_m,
        input logic          rsp,
        input logic [AW-1:0] rsp_rd,
        input logic          wr_w,
        input logic [AW-1:0] rd_w
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (r != '0) begin
            if (wr_m && (rd_m == r)) begin
                sel = FWD_M;
            end else if (rsp && (rsp_rd == r)) begin
                sel = FWD_RESP;
            end else if (wr_w && (rd_w == r)) begin
                sel = FWD_W;
            end
        end
        return sel;
    endfunction

    always_comb begin
        o_fwd_ae = FWD_RF;
        o_fwd_be = FWD_RF;
        if ((FWD_EN != 0) && !i_rst) begin
            o_fwd_ae = fwd_sel(i_rs1_addr_e, i_reg_wr_en_m, i_rd_addr_m,
                               i_ld_resp_valid, i_ld_resp_rd, i_reg_wr_en_w, i_rd_addr_w);
            o_fwd_be = fwd_sel(i_rs2_addr_e, i_reg_wr_en_m, i_rd_addr_m,
                               i_ld_resp_valid, i_ld_resp_rd, i_reg_wr_en_w, i_rd_addr_w);
        end
    end

    // State outputs read zero while reset is held, even before the first edge.
    assign o_busy_vec = i_rst ? '0 : busy_q;
    assign o_ld_cnt   = i_rst ? 4'd0 : cnt_q;

endmodule

// File: tb/tb_riscv_scoreboard_hazard_unit.sv
// tb/tb_riscv_scoreboard_hazard_unit.sv - directed vector bench for riscv_scoreboard_hazard_unit

module tb_riscv_scoreboard_hazard_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs1_d, rs2_d, rd_d, rs1_e, rs2_e, rd_e, rd_m, rd_w, iss_rd, rsp_rd;
    logic       u1, u2, wr_d, ld_d, wr_e, ld_e, wr_m, wr_w, iss, rsp, redir;

    logic        sf0, sd0, fd0, fe0;
    logic [1:0]  fa0, fb0;
    logic [31:0] busy0;
    logic [3:0]  cnt0;
    logic        sf1, sd1, fd1, fe1;
    logic [1:0]  fa1, fb1;
    logic [31:0] busy1;
    logic [3:0]  cnt1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    riscv_scoreboard_hazard_unit #(.NREG(32), .MAX_OUT(4), .FWD_EN(1)) dut0 (
        .i_clk(clk), .i_rst(rst),
        .i_rs1_addr_d(rs1_d), .i_rs2_addr_d(rs2_d), .i_rs1_used_d(u1), .i_rs2_used_d(u2),
        .i_rd_addr_d(rd_d), .i_reg_wr_en_d(wr_d), .i_is_load_d(ld_d),
        .i_rs1_addr_e(rs1_e), .i_rs2_addr_e(rs2_e), .i_rd_addr_e(rd_e),
        .i_reg_wr_en_e(wr_e), .i_is_load_e(ld_e),
        .i_rd_addr_m(rd_m), .i_reg_wr_en_m(wr_m), .i_rd_addr_w(rd_w), .i_reg_wr_en_w(wr_w),
        .i_ld_issue(iss), .i_ld_issue_rd(iss_rd), .i_ld_resp_valid(rsp), .i_ld_resp_rd(rsp_rd),
        .i_redirect_e(redir),
        .o_stall_f(sf0), .o_stall_d(sd0), .o_flush_d(fd0), .o_flush_e(fe0),
        .o_fwd_ae(fa0), .o_fwd_be(fb0), .o_busy_vec(busy0), .o_ld_cnt(cnt0)
    );

    riscv_scoreboard_hazard_unit #(.NREG(32), .MAX_OUT(4), .FWD_EN(0)) dut1 (
        .i_clk(clk), .i_rst(rst),
        .i_rs1_addr_d(rs1_d), .i_rs2_addr_d(rs2_d), .i_rs1_used_d(u1), .i_rs2_used_d(u2),
        .i_rd_addr_d(rd_d), .i_reg_wr_en_d(wr_d), .i_is_load_d(ld_d),
        .i_rs1_addr_e(rs1_e), .i_rs2_addr_e(rs2_e), .i_rd_addr_e(rd_e),
        .i_reg_wr_en_e(wr_e), .i_is_load_e(ld_e),
        .i_rd_addr_m(rd_m), .i_reg_wr_en_m(wr_m), .i_rd_addr_w(rd_w), .i_reg_wr_en_w(wr_w),
        .i_ld_issue(iss), .i_ld_issue_rd(iss_rd), .i_ld_resp_valid(rsp), .i_ld_resp_rd(rsp_rd),
        .i_redirect_e(redir),
        .o_stall_f(sf1), .o_stall_d(sd1), .o_flush_d(fd1), .o_flush_e(fe1),
        .o_fwd_ae(fa1), .o_fwd_be(fb1), .o_busy_vec(busy1), .o_ld_cnt(cnt1)
    );

    typedef struct packed {
        logic [4:0] rs1_d, rs2_d, rd_d, rs1_e, rs2_e, rd_e, rd_m, rd_w, iss_rd, rsp_rd;
        logic       u1, u2, wr_d, ld_d, wr_e, ld_e, wr_m, wr_w, iss, rsp, redir;
        logic       e_stall, e_fd, e_fe;
        logic [1:0] e_fa, e_fb;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        {rs1_d, rs2_d, rd_d, rs1_e, rs2_e, rd_e, rd_m, rd_w, iss_rd, rsp_rd} = '0;
        {u1, u2, wr_d, ld_d, wr_e, ld_e, wr_m, wr_w, iss, rsp, redir} = '0;
    endtask

    task automatic drive_random();
        {rs1_d, rs2_d, rd_d, rs1_e, rs2_e, rd_e, rd_m, rd_w, iss_rd, rsp_rd} = 50'($urandom) ^ (50'($urandom) << 32);
        {u1, u2, wr_d, ld_d, wr_e, ld_e, wr_m, wr_w, iss, rsp, redir} = 11'($urandom);
    endtask

    task automatic apply_vec(input vec_t v);
        rs1_d = v.rs1_d; rs2_d = v.rs2_d; rd_d = v.rd_d; rs1_e = v.rs1_e; rs2_e = v.rs2_e;
        rd_e = v.rd_e; rd_m = v.rd_m; rd_w = v.rd_w; iss_rd = v.iss_rd; rsp_rd = v.rsp_rd;
        u1 = v.u1; u2 = v.u2; wr_d = v.wr_d; ld_d = v.ld_d; wr_e = v.wr_e; ld_e = v.ld_e;
        wr_m = v.wr_m; wr_w = v.wr_w; iss = v.iss; rsp = v.rsp; redir = v.redir;
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_ctl0"}, 64'({sf0, sd0, fd0, fe0, fa0, fb0}), 64'd0);
        chk({name, "_busy0"}, 64'(busy0), 64'd0);
        chk({name, "_cnt0"}, 64'(cnt0), 64'd0);
        chk({name, "_ctl1"}, 64'({sf1, sd1, fd1, fe1, fa1, fb1}), 64'd0);
        chk({name, "_busy1"}, 64'(busy1), 64'd0);
        chk({name, "_cnt1"}, 64'(cnt1), 64'd0);
    endtask

    task automatic build_vectors();
        vec_t v;
        v = '0;                                                     vq.push_back(v);
        v = '0; v.iss = 1; v.iss_rd = 7; v.rs1_d = 7; v.u1 = 1;
        v.e_stall = 1; v.e_fe = 1;                                  vq.push_back(v);
        v = '0; v.iss = 1; v.iss_rd = 7; v.rs1_d = 7;               vq.push_back(v);
        v = '0; v.ld_e = 1; v.rd_e = 9; v.rs2_d = 9; v.u2 = 1;
        v.e_stall = 1; v.e_fe = 1;                                  vq.push_back(v);
        v = '0; v.ld_e = 1; v.rd_e = 0; v.rs1_d = 0; v.u1 = 1;      vq.push_back(v);
        v = '0; v.ld_e = 1; v.rd_e = 4; v.wr_d = 1; v.rd_d = 4;
        v.e_stall = 1; v.e_fe = 1;                                  vq.push_back(v);
        v = '0; v.iss = 1; v.iss_rd = 6; v.wr_d = 1; v.rd_d = 6;
        v.e_stall = 1; v.e_fe = 1;                                  vq.push_back(v);
        v = '0; v.iss = 1; v.iss_rd = 0; v.wr_d = 1; v.rd_d = 0;    vq.push_back(v);
        v = '0; v.ld_d = 1; v.ld_e = 1; v.rd_e = 2; v.iss = 1; v.iss_rd = 2;
                                                                    vq.push_back(v);
        v = '0; v.redir = 1; v.e_fd = 1; v.e_fe = 1;                vq.push_back(v);
        v = '0; v.redir = 1; v.iss = 1; v.iss_rd = 7; v.rs1_d = 7; v.u1 = 1;
        v.e_fd = 1; v.e_fe = 1;                                     vq.push_back(v);
        v = '0; v.wr_m = 1; v.rd_m = 3; v.rsp = 1; v.rsp_rd = 3; v.wr_w = 1; v.rd_w = 3;
        v.rs1_e = 3; v.rs2_e = 3; v.e_fa = 2'b10; v.e_fb = 2'b10;   vq.push_back(v);
        v = '0; v.rsp = 1; v.rsp_rd = 3; v.wr_w = 1; v.rd_w = 3;
        v.rs1_e = 3; v.rs2_e = 3; v.e_fa = 2'b11; v.e_fb = 2'b11;   vq.push_back(v);
        v = '0; v.wr_w = 1; v.rd_w = 3;
        v.rs1_e = 3; v.rs2_e = 3; v.e_fa = 2'b01; v.e_fb = 2'b01;   vq.push_back(v);
        v = '0; v.wr_m = 1; v.rd_m = 0; v.rsp = 1; v.rsp_rd = 0; v.wr_w = 1; v.rd_w = 0;
                                                                    vq.push_back(v);
        v = '0; v.wr_m = 1; v.rd_m = 3; v.wr_w = 1; v.rd_w = 8;
        v.rs1_e = 3; v.rs2_e = 8; v.e_fa = 2'b10; v.e_fb = 2'b01;   vq.push_back(v);
        v = '0; v.wr_e = 1; v.rd_e = 1; v.rs1_d = 1; v.u1 = 1;      vq.push_back(v);
    endtask

    initial begin
        rst = 1'b1;
        drive_random();
        build_vectors();

        // Reset held two cycles under random inputs.
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            drive_random();
            #1;
            chk_all_zero($sformatf("reset_c%0d", c));
        end
        @(negedge clk);
        rst = 1'b0;
        drive_idle();
        #1;
        chk("post_reset_busy", 64'(busy0), 64'd0);
        chk("post_reset_cnt", 64'(cnt0), 64'd0);

        // Combinational vectors against an empty scoreboard; issue/response
        // are withdrawn before the next edge so state stays empty.
        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            apply_vec(vq[i]);
            #1;
            chk($sformatf("v%0d_stall_f", i), 64'(sf0), 64'(vq[i].e_stall));
            chk($sformatf("v%0d_stall_d", i), 64'(sd0), 64'(vq[i].e_stall));
            chk($sformatf("v%0d_flush_d", i), 64'(fd0), 64'(vq[i].e_fd));
            chk($sformatf("v%0d_flush_e", i), 64'(fe0), 64'(vq[i].e_fe));
            chk($sformatf("v%0d_fwd_a", i), 64'(fa0), 64'(vq[i].e_fa));
            chk($sformatf("v%0d_fwd_b", i), 64'(fb0), 64'(vq[i].e_fb));
            chk($sformatf("v%0d_nofwd_sel", i), 64'({fa1, fb1}), 64'd0);
            drive_idle();
        end
        chk("vec_state_busy", 64'(busy0), 64'd0);

        // Load to x5, response six cycles later, decode reading x5;
        // a redirect lands in the middle of the stall.
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            drive_idle();
            rs1_d = 5; u1 = 1;
            if (c == 0) begin iss = 1; iss_rd = 5; end
            if (c == 6) begin rsp = 1; rsp_rd = 5; end
            redir = (c == 3);
            #1;
            chk($sformatf("lu_c%0d_stall_f", c), 64'(sf0), 64'(c <= 6 && c != 3));
            chk($sformatf("lu_c%0d_stall_d", c), 64'(sd0), 64'(c <= 6 && c != 3));
            chk($sformatf("lu_c%0d_flush_d", c), 64'(fd0), 64'(c == 3));
            chk($sformatf("lu_c%0d_flush_e", c), 64'(fe0), 64'(c <= 6));
            chk($sformatf("lu_c%0d_busy5", c), 64'(busy0[5]), 64'(c >= 1 && c <= 6));
            chk($sformatf("lu_c%0d_cnt", c), 64'(cnt0), 64'(c >= 1 && c <= 6));
        end

        // Outstanding-load limit.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            drive_idle();
            iss = 1; iss_rd = 5'(10 + k);
            #1;
            chk($sformatf("full_fill%0d_cnt", k), 64'(cnt0), 64'(k));
        end
        @(negedge clk);
        drive_idle();
        ld_d = 1;
        #1;
        chk("full_cnt4", 64'(cnt0), 64'd4);
        chk("full_stall", 64'(sf0), 64'd1);
        chk("full_busy", 64'(busy0), 64'h3C00);
        @(negedge clk);
        rsp = 1; rsp_rd = 10;
        #1;
        chk("full_resp_cycle_stall", 64'(sf0), 64'd1);
        @(negedge clk);
        rsp = 0;
        #1;
        chk("full_release_stall", 64'(sf0), 64'd0);
        chk("full_release_cnt", 64'(cnt0), 64'd3);
        chk("full_release_busy", 64'(busy0), 64'h3800);
        ld_d = 0;
        for (int k = 1; k < 5; k++) begin
            @(negedge clk);
            rsp = 1; rsp_rd = (k == 4) ? 5'd10 : 5'(10 + k);
        end
        @(negedge clk);
        drive_idle();
        #1;
        chk("drain_empty_cnt", 64'(cnt0), 64'd0);
        chk("drain_empty_busy", 64'(busy0), 64'd0);

        // Same-cycle issue and response on x6: set wins.
        @(negedge clk); iss = 1; iss_rd = 6;
        @(negedge clk); rsp = 1; rsp_rd = 6;
        @(negedge clk); drive_idle(); #1;
        chk("setclr_busy", 64'(busy0), 64'h40);
        chk("setclr_cnt", 64'(cnt0), 64'd1);
        rsp = 1; rsp_rd = 6;
        @(negedge clk); drive_idle(); #1;
        chk("setclr_done_busy", 64'(busy0), 64'd0);
        chk("setclr_done_cnt", 64'(cnt0), 64'd0);

        // Load to x0 counts but never marks the scoreboard.
        iss = 1; iss_rd = 0;
        @(negedge clk); drive_idle(); #1;
        chk("x0_busy", 64'(busy0), 64'd0);
        chk("x0_cnt", 64'(cnt0), 64'd1);
        rsp = 1; rsp_rd = 0;
        @(negedge clk); drive_idle(); #1;
        chk("x0_cnt_after", 64'(cnt0), 64'd0);

        // No-forwarding build: ALU result to x1 moves E -> M -> W.
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            drive_idle();
            rs1_d = 1; u1 = 1; rs1_e = 1;
            if (c == 0) begin wr_e = 1; rd_e = 1; end
            if (c == 1) begin wr_m = 1; rd_m = 1; end
            if (c == 2) begin wr_w = 1; rd_w = 1; end
            #1;
            chk($sformatf("nf_c%0d_stall1", c), 64'(sf1), 64'(c < 3));
            chk($sformatf("nf_c%0d_fwd1", c), 64'(fa1), 64'd0);
            chk($sformatf("nf_c%0d_stall0", c), 64'(sf0), 64'd0);
            chk($sformatf("nf_c%0d_fwd0", c), 64'(fa0), (c == 1) ? 64'd2 : (c == 2) ? 64'd1 : 64'd0);
        end
        @(negedge clk);
        drive_idle();
        rs1_d = 0; u1 = 1; wr_e = 1; rd_e = 0; wr_m = 1; rd_m = 0; wr_d = 1; rd_d = 0;
        #1;
        chk("nf_x0_stall1", 64'(sf1), 64'd0);

        // Reset in the middle of outstanding loads, then a stale response.
        @(negedge clk); drive_idle(); iss = 1; iss_rd = 20;
        @(negedge clk); iss_rd = 21;
        @(negedge clk); drive_idle(); #1;
        chk("mid_pre_cnt", 64'(cnt0), 64'd2);
        rs1_d = 20; u1 = 1;
        rst = 1;
        #1;
        chk_all_zero("mid_rst");
        @(negedge clk);
        rst = 0;
        #1;
        chk("mid_post_busy", 64'(busy0), 64'd0);
        chk("mid_post_stall", 64'(sf0), 64'd0);
        rsp = 1; rsp_rd = 20;
        @(negedge clk); drive_idle(); #1;
        chk("mid_stale_cnt", 64'(cnt0), 64'd0);
        chk("mid_stale_busy", 64'(busy0), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
